// File: rtl/ysyx_23060201_alu_seq_if.sv
// Request/response handshake bundle for the sequential ALU.
// master = requester/consumer side, slave = ALU side.
interface ysyx_23060201_alu_seq_if #(parameter int XLEN = 32);
   logic            in_valid;
   logic            in_ready;
   logic [XLEN-1:0] a;
   logic [XLEN-1:0] b;
   logic [4:0]      ctl;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] res;

   modport master (output in_valid, a, b, ctl, out_ready,
                   input  in_ready, out_valid, res);
   modport slave  (input  in_valid, a, b, ctl, out_ready,
                   output in_ready, out_valid, res);
endinterface

// File: rtl/ysyx_23060201_alu_seq.sv
// Sequential RV ALU: single-cycle base ops, optional bit-serial mul/div
// (enabled by YSYX_23060201_ALU_MULDIV_EN) sharing one 2*XLEN work register.
module ysyx_23060201_alu_seq #(
   parameter int XLEN = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   ysyx_23060201_alu_seq_if.slave  bus
);
   localparam int SHW = $clog2(XLEN);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t          state, state_nxt;
   logic [XLEN-1:0] res_q;
   logic [XLEN-1:0] base_res;
   logic            accept;
   logic            m_go;
   logic            last;
   logic [SHW-1:0]  shamt;

   assign accept        = bus.in_valid & bus.in_ready;
   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.res       = res_q;
   assign shamt         = bus.b[SHW-1:0];

   always_comb begin
      base_res = '0;
      if (!bus.ctl[4]) begin
         case (bus.ctl[3:0])
            4'b0000: base_res = bus.a + bus.b;
            4'b1000: base_res = bus.a - bus.b;
            4'b0001: base_res = bus.a << shamt;
            4'b0010: base_res = {{(XLEN-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
            4'b0011: base_res = {{(XLEN-1){1'b0}}, bus.a < bus.b};
            4'b0100: base_res = bus.a ^ bus.b;
            4'b0101: base_res = bus.a >> shamt;
            4'b1101: base_res = XLEN'($unsigned($signed(bus.a) >>> shamt));
            4'b0110: base_res = bus.a | bus.b;
            4'b0111: base_res = bus.a & bus.b;
            default: base_res = '0;
         endcase
      end
   end

`ifdef YSYX_23060201_ALU_MULDIV_EN
   logic [SHW-1:0]    cnt;
   // hi half = partial product / remainder, lo half = multiplier / quotient
   logic [2*XLEN-1:0] acc, acc_step, acc_sgn;
   logic [XLEN-1:0]   opd, a_keep, m_res;
   logic [2:0]        f3;
   logic              neg, dz;

   logic              is_div_in, sgn_a, sgn_b, na, nb, neg_in;
   logic [XLEN-1:0]   mag_a, mag_b;
   logic [XLEN-1:0]   hi, lo, hi_s, lo_s;
   logic [XLEN:0]     sum, sh, diff;

   always_comb begin
      is_div_in = bus.ctl[2];
      sgn_a     = is_div_in ? !bus.ctl[0] : (bus.ctl[1:0] != 2'b11);
      sgn_b     = is_div_in ? !bus.ctl[0] : !bus.ctl[1];
      na        = sgn_a & bus.a[XLEN-1];
      nb        = sgn_b & bus.b[XLEN-1];
      mag_a     = na ? -bus.a : bus.a;
      mag_b     = nb ? -bus.b : bus.b;
      // remainder sign follows the dividend; everything else is sign xor
      neg_in    = (is_div_in && bus.ctl[1]) ? na : (na ^ nb);
   end

   always_comb begin
      hi   = acc[2*XLEN-1:XLEN];
      lo   = acc[XLEN-1:0];
      sum  = {1'b0, hi} + ({1'b0, opd} & {(XLEN+1){lo[0]}});
      sh   = {hi, lo[XLEN-1]};
      diff = sh - {1'b0, opd};
      if (!f3[2])
         acc_step = {sum, lo[XLEN-1:1]};
      else if (!diff[XLEN])
         acc_step = {diff[XLEN-1:0], lo[XLEN-2:0], 1'b1};
      else
         acc_step = {sh[XLEN-1:0], lo[XLEN-2:0], 1'b0};
   end

   always_comb begin
      acc_sgn = neg ? -acc_step : acc_step;
      hi_s    = acc_step[2*XLEN-1:XLEN];
      lo_s    = acc_step[XLEN-1:0];
      m_res   = '0;
      if (!f3[2])
         m_res = (f3[1:0] == 2'b00) ? acc_sgn[XLEN-1:0] : acc_sgn[2*XLEN-1:XLEN];
      else if (!f3[1])
         m_res = dz ? '1 : (neg ? -lo_s : lo_s);
      else
         m_res = dz ? a_keep : (neg ? -hi_s : hi_s);
   end

   assign m_go = bus.ctl[4];
   assign last = (cnt == SHW'(XLEN-1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt    <= '0;
         acc    <= '0;
         opd    <= '0;
         a_keep <= '0;
         f3     <= '0;
         neg    <= 1'b0;
         dz     <= 1'b0;
      end else if (state == IDLE && accept && m_go) begin
         cnt    <= '0;
         acc    <= {{XLEN{1'b0}}, is_div_in ? mag_a : mag_b};
         opd    <= is_div_in ? mag_b : mag_a;
         a_keep <= bus.a;
         f3     <= bus.ctl[2:0];
         neg    <= neg_in;
         dz     <= (bus.b == '0);
      end else if (state == BUSY) begin
         cnt    <= cnt + SHW'(1);
         acc    <= acc_step;
      end
   end
`else
   assign m_go = 1'b0;
   assign last = 1'b1;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = m_go ? BUSY : DONE;
         BUSY:    if (last) state_nxt = DONE;
         DONE:    if (bus.out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         res_q <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && accept && !m_go)
            res_q <= base_res;
`ifdef YSYX_23060201_ALU_MULDIV_EN
         else if (state == BUSY && last)
            res_q <= m_res;
`endif
      end
   end
endmodule

// File: tb/tb_ysyx_23060201_alu_seq.sv
// Randomized bench for ysyx_23060201_alu_seq against an arithmetic reference model.
module tb_ysyx_23060201_alu_seq;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_err = 0;

   ysyx_23060201_alu_seq_if #(.XLEN(32)) bus();

   ysyx_23060201_alu_seq #(.XLEN(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

`ifdef YSYX_23060201_ALU_MULDIV_EN
   localparam bit MD = 1'b1;
`else
   localparam bit MD = 1'b0;
`endif

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
      longint      ps, psu;
      logic [63:0] pu;
      int          ia, ib;
      ia  = int'(a);
      ib  = int'(b);
      ps  = longint'(ia) * longint'(ib);
      psu = longint'(ia) * longint'({32'h0, b});
      pu  = {32'h0, a} * {32'h0, b};
      if (c[4]) begin
         if (!MD) return 32'h0;
         case (c[2:0])
            3'd0: return ps[31:0];
            3'd1: return ps[63:32];
            3'd2: return psu[63:32];
            3'd3: return pu[63:32];
            3'd4: return (b == 0) ? 32'hFFFFFFFF : (a == 32'h80000000 && b == 32'hFFFFFFFF) ? a : 32'(ia / ib);
            3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: return (b == 0) ? a : (a == 32'h80000000 && b == 32'hFFFFFFFF) ? 32'h0 : 32'(ia % ib);
            default: return (b == 0) ? a : a % b;
         endcase
      end
      case (c[3:0])
         4'b0000: return a + b;
         4'b1000: return a - b;
         4'b0001: return a << b[4:0];
         4'b0010: return (ia < ib) ? 32'd1 : 32'd0;
         4'b0011: return (a < b) ? 32'd1 : 32'd0;
         4'b0100: return a ^ b;
         4'b0101: return a >> b[4:0];
         4'b1101: return 32'(ia >>> b[4:0]);
         4'b0110: return a | b;
         4'b0111: return a & b;
         default: return 32'h0;
      endcase
   endfunction

   task automatic run_op(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b, input bit hold);
      logic [31:0] exp_res, seen;
      int          lat, exp_lat;
      exp_res = model(c, a, b);
      exp_lat = (c[4] && MD) ? 33 : 1;
      chk("in_ready_idle", bus.in_ready, 1);
      bus.ctl = c; bus.a = a; bus.b = b; bus.in_valid = 1'b1; bus.out_ready = !hold;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.a = $urandom; bus.b = $urandom; bus.ctl = 5'($urandom);
      lat = 1;
      while (!bus.out_valid && lat < 200) begin
         if (bus.in_ready) chk("in_ready_busy", bus.in_ready, 0);
         @(posedge clk); #1;
         lat++;
      end
      chk($sformatf("latency ctl=%b", c), lat, exp_lat);
      chk($sformatf("res ctl=%b a=%h b=%h", c, a, b), bus.res, exp_res);
      if (hold) begin
         seen = bus.res;
         repeat (5) begin
            @(posedge clk); #1;
            chk("hold_valid", bus.out_valid, 1);
            chk("hold_res", bus.res, seen);
            chk("hold_in_ready", bus.in_ready, 0);
         end
         bus.out_ready = 1'b1;
      end
      @(posedge clk); #1;
      chk("retire_in_ready", bus.in_ready, 1);
      chk("retire_out_valid", bus.out_valid, 0);
   endtask

   function automatic logic [31:0] pick();
      logic [31:0] corner [5];
      corner = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
      if ($urandom_range(3) == 0) return corner[$urandom_range(4)];
      return $urandom;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.ctl = '0; bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_res", bus.res, 0);

      run_op(5'b01000, 32'd5, 32'd7, 1'b0);
      run_op(5'b01101, 32'h80000000, 32'd4, 1'b0);
      run_op(5'b00001, 32'd1, 32'd31, 1'b0);
      run_op(5'b01010, 32'd3, 32'd4, 1'b0);
      run_op(5'b10001, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
      run_op(5'b10011, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
      run_op(5'b10100, 32'h80000000, 32'hFFFFFFFF, 1'b0);
      run_op(5'b10110, 32'h80000000, 32'hFFFFFFFF, 1'b0);
      run_op(5'b10110, 32'd9, 32'd0, 1'b0);
      run_op(5'b10100, 32'hFFFFFFF9, 32'd0, 1'b0);
      run_op(5'b10000, 32'hFFFFFFF9, 32'd3, 1'b1);
      run_op(5'b00000, 32'h12345678, 32'h9ABCDEF0, 1'b1);

      // reset mid-divide discards the op
      bus.ctl = 5'b10101; bus.a = 32'd100; bus.b = 32'd7; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
      @(posedge clk); #1 bus.in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      chk("midrst_out_valid", bus.out_valid, 0);
      chk("midrst_res", bus.res, 0);
      chk("midrst_in_ready", bus.in_ready, 1);
      run_op(5'b10101, 32'd100, 32'd7, 1'b0);

      for (int i = 0; i < 150; i++)
         run_op(5'($urandom), pick(), pick(), ($urandom_range(7) == 0));

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
